// File: rtl/fpaddsub_lzc_pipe.sv
// Two-stage leading-zero count and normalising left shift with valid/ready flow control.
// Stage 1 counts zeros per GROUP-bit group; stage 2 picks the first non-zero group and shifts.
module fpaddsub_lzc_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8,
  parameter int TAG_W = 4,
  localparam int ZW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ZW-1:0]    Z,
  output logic [WIDTH-1:0] N,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG = WIDTH / GROUP;
  localparam int GW = $clog2(GROUP) + 1;

  // Handshake: a word transfers on a rising edge where valid & ready are both high.
  // One global enable advances both stages together; when the output is held the
  // whole pipe freezes, so in_ready is simply that enable.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  function automatic logic [GW-1:0] grp_lzc(input logic [GROUP-1:0] g);
    logic [GW-1:0] c;
    c = GW'(GROUP);
    for (int i = 0; i < GROUP; i++) begin
      if (g[i]) c = GW'(GROUP - 1 - i);
    end
    return c;
  endfunction

  // Stage 1 state
  logic             v1_q;
  logic [WIDTH-1:0] a1_q;
  logic [TAG_W-1:0] tag1_q;
  logic [GW-1:0]    gcnt_q [NG];
  logic [GW-1:0]    gcnt_d [NG];
  logic [NG-1:0]    gzero_q, gzero_d;

  // Stage 2 state
  logic             v2_q;
  logic [ZW-1:0]    z2_q, z_d;
  logic [WIDTH-1:0] n2_q, n_d;
  logic             zero2_q, zero_d;
  logic [TAG_W-1:0] tag2_q;

  // Group 0 is the most significant group.
  always_comb begin
    logic [GROUP-1:0] grp;
    grp     = '0;
    gzero_d = '0;
    for (int g = 0; g < NG; g++) begin
      grp        = A[WIDTH-1-g*GROUP -: GROUP];
      gcnt_d[g]  = grp_lzc(grp);
      gzero_d[g] = (grp == '0);
    end
  end

  // Scanning from the least significant group upward leaves the first non-zero group's count.
  always_comb begin
    z_d = ZW'(WIDTH);
    for (int g = NG - 1; g >= 0; g--) begin
      if (!gzero_q[g]) z_d = ZW'(g * GROUP) + ZW'(gcnt_q[g]);
    end
    n_d    = a1_q << z_d;
    zero_d = &gzero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      tag1_q  <= '0;
      gcnt_q  <= '{default: '0};
      gzero_q <= '0;
      v2_q    <= 1'b0;
      z2_q    <= '0;
      n2_q    <= '0;
      zero2_q <= 1'b0;
      tag2_q  <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      a1_q    <= A;
      tag1_q  <= in_tag;
      gcnt_q  <= gcnt_d;
      gzero_q <= gzero_d;
      v2_q    <= v1_q;
      z2_q    <= z_d;
      n2_q    <= n_d;
      zero2_q <= zero_d;
      tag2_q  <= tag1_q;
    end
  end

  assign out_valid = v2_q;
  assign Z         = z2_q;
  assign N         = n2_q;
  assign zero      = zero2_q;
  assign out_tag   = tag2_q;

endmodule
